// File: rtl/bus_trace_pkg.sv
// Shared encodings for the bus trace engine.
// Defining BUS_TRACE_TIMESTAMP_EN widens every record by a 16-bit inter-record cycle count.
package bus_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_TRIGGERED = 3'd2,
    ST_DONE      = 3'd3,
    ST_DUMP      = 3'd4
  } state_t;

  localparam int FLAG_W      = 4;
  localparam int FLAG_DSACK0 = 0;
  localparam int FLAG_DSACK1 = 1;
  localparam int FLAG_BERR   = 2;
  localparam int FLAG_RW     = 3;
  localparam int TIMESTAMP_W = 16;

  function automatic int rec_w(input int ad_w);
`ifdef BUS_TRACE_TIMESTAMP_EN
    return 2 * ad_w + FLAG_W + TIMESTAMP_W;
`else
    return 2 * ad_w + FLAG_W;
`endif
  endfunction

endpackage

// File: rtl/bus_cycle_decoder.sv
// Synchronises the asynchronous bus into comm_clock and turns each terminated AS cycle
// into one {addr, data, flags} capture with a single-cycle rec_stb.
module bus_cycle_decoder import bus_trace_pkg::*; #(
  parameter int AD_W        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              comm_clock,
  input  logic              reset,
  input  logic              bus_as_n,
  input  logic              bus_ds_n,
  input  logic              bus_rw,
  input  logic              bus_berr_n,
  input  logic [1:0]        bus_dsack_n,
  input  logic [AD_W-1:0]   bus_ad,
  output logic [AD_W-1:0]   cyc_addr,
  output logic [AD_W-1:0]   cyc_data,
  output logic [FLAG_W-1:0] cyc_flags,
  output logic              rec_stb
);

  localparam int CTL_W = 6;

  logic [CTL_W-1:0] ctl_sync [SYNC_STAGES];
  logic [AD_W-1:0]  ad_sync  [SYNC_STAGES];
  logic             as_s, rw_s, berr_s, unused_ds;
  logic [1:0]       dsack_s;
  logic [AD_W-1:0]  ad_s;
  logic             as_prev, in_cycle, as_fall, term, rec_hit;
  logic [FLAG_W-1:0] flags_nxt;

  // Strobes reset to their inactive level so a reset never fabricates an edge.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) ctl_sync[i] <= '1;
    end else begin
      ctl_sync[0] <= {bus_as_n, bus_ds_n, bus_rw, bus_berr_n, bus_dsack_n};
      for (int i = 1; i < SYNC_STAGES; i++) ctl_sync[i] <= ctl_sync[i-1];
    end
  end

  always_ff @(posedge comm_clock) begin
    ad_sync[0] <= bus_ad;
    for (int i = 1; i < SYNC_STAGES; i++) ad_sync[i] <= ad_sync[i-1];
  end

  assign as_s      = ctl_sync[SYNC_STAGES-1][5];
  assign unused_ds = ctl_sync[SYNC_STAGES-1][4];
  assign rw_s      = ctl_sync[SYNC_STAGES-1][3];
  assign berr_s    = ctl_sync[SYNC_STAGES-1][2];
  assign dsack_s   = ctl_sync[SYNC_STAGES-1][1:0];
  assign ad_s      = ad_sync[SYNC_STAGES-1];

  assign as_fall = as_prev && !as_s;
  assign term    = !dsack_s[0] || !dsack_s[1] || !berr_s;
  assign rec_hit = in_cycle && !as_s && term;

  always_comb begin
    flags_nxt              = '0;
    flags_nxt[FLAG_RW]     = rw_s;
    flags_nxt[FLAG_BERR]   = !berr_s;
    flags_nxt[FLAG_DSACK1] = !dsack_s[1];
    flags_nxt[FLAG_DSACK0] = !dsack_s[0];
  end

  // Decode stage: a cycle ends either with one record or, if AS rises first, with nothing.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      as_prev  <= 1'b1;
      in_cycle <= 1'b0;
      rec_stb  <= 1'b0;
    end else begin
      as_prev <= as_s;
      rec_stb <= rec_hit;
      if (as_fall)
        in_cycle <= 1'b1;
      else if (in_cycle && (as_s || term))
        in_cycle <= 1'b0;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (as_fall) cyc_addr <= ad_s;
    if (rec_hit) begin
      cyc_data  <= ad_s;
      cyc_flags <= flags_nxt;
    end
  end

endmodule

// File: rtl/bus_trace_capture.sv
// Bus-cycle trace engine: trigger FSM, circular record buffer and oldest-first dump port.
// Optional BUS_TRACE_TIMESTAMP_EN appends a saturating cycles-since-previous-record field.
module bus_trace_capture import bus_trace_pkg::*; #(
  parameter int  AD_W        = 32,
  parameter int  DEPTH       = 256,
  parameter int  PRE_TRIG    = 32,
  parameter int  SYNC_STAGES = 2,
  localparam int REC_W       = rec_w(AD_W),
  localparam int PTR_W       = $clog2(DEPTH)
) (
  input  logic             comm_clock,
  input  logic             reset,
  input  logic             arm,
  input  logic             force_trigger,
  input  logic             dump_start,
  input  logic [AD_W-1:0]  trig_addr,
  input  logic [AD_W-1:0]  trig_mask,
  input  logic             bus_as_n,
  input  logic             bus_ds_n,
  input  logic             bus_rw,
  input  logic             bus_berr_n,
  input  logic [1:0]       bus_dsack_n,
  input  logic [AD_W-1:0]  bus_ad,
  output logic [REC_W-1:0] rec_data,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       capture_state,
  output logic [PTR_W:0]   rec_count
);

  localparam logic [PTR_W-1:0] PRE_MAX   = PTR_W'(PRE_TRIG);
  localparam logic [PTR_W-1:0] POST_LOAD = PTR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [PTR_W:0]   DUMP_BASE = (PTR_W+1)'(DEPTH - PRE_TRIG);

  logic [AD_W-1:0]   cyc_addr, cyc_data;
  logic [FLAG_W-1:0] cyc_flags;
  logic              rec_stb;
  logic [REC_W-1:0]  wr_rec;
  logic [REC_W-1:0]  mem [DEPTH];

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, start_ptr, pre_cnt, post_rem;
  logic [PTR_W:0]    dump_rem;
  logic              force_pend, rd_req, dump_q, wr_en, addr_hit;

  bus_cycle_decoder #(
    .AD_W        (AD_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_decoder (
    .comm_clock  (comm_clock),
    .reset       (reset),
    .bus_as_n    (bus_as_n),
    .bus_ds_n    (bus_ds_n),
    .bus_rw      (bus_rw),
    .bus_berr_n  (bus_berr_n),
    .bus_dsack_n (bus_dsack_n),
    .bus_ad      (bus_ad),
    .cyc_addr    (cyc_addr),
    .cyc_data    (cyc_data),
    .cyc_flags   (cyc_flags),
    .rec_stb     (rec_stb)
  );

`ifdef BUS_TRACE_TIMESTAMP_EN
  logic [TIMESTAMP_W-1:0] ts_cnt;

  always_ff @(posedge comm_clock) begin
    if (reset || (arm && state == ST_IDLE) || rec_stb)
      ts_cnt <= '0;
    else if (ts_cnt != '1)
      ts_cnt <= ts_cnt + 1'b1;
  end

  assign wr_rec = {cyc_addr, cyc_data, cyc_flags, ts_cnt};
`else
  assign wr_rec = {cyc_addr, cyc_data, cyc_flags};
`endif

  assign capture_state = state;
  assign wr_en    = rec_stb && (state == ST_ARMED || state == ST_TRIGGERED);
  assign addr_hit = ((cyc_addr ^ trig_addr) & trig_mask) == '0;

  always_ff @(posedge comm_clock) begin
    if (wr_en) mem[wr_ptr] <= wr_rec;
  end

  // Read stage: rec_data is the buffer's output register and only reloads on a read request.
  always_ff @(posedge comm_clock) begin
    if (reset)
      rec_data <= '0;
    else if (rd_req)
      rec_data <= mem[rd_ptr];
  end

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      start_ptr  <= '0;
      pre_cnt    <= '0;
      post_rem   <= '0;
      dump_rem   <= '0;
      rec_count  <= '0;
      force_pend <= 1'b0;
      rd_req     <= 1'b0;
      rec_valid  <= 1'b0;
      dump_q     <= 1'b0;
    end else begin
      dump_q <= dump_start;
      rd_req <= 1'b0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (rec_count != '1) rec_count <= rec_count + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (arm) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            start_ptr  <= '0;
            pre_cnt    <= '0;
            rec_count  <= '0;
            force_pend <= 1'b0;
            state      <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (force_trigger) force_pend <= 1'b1;
          if (rec_stb) begin
            if (addr_hit || force_pend || force_trigger) begin
              start_ptr  <= wr_ptr - pre_cnt;
              post_rem   <= POST_LOAD;
              force_pend <= 1'b0;
              state      <= (POST_LOAD == '0) ? ST_DONE : ST_TRIGGERED;
            end else if (pre_cnt != PRE_MAX) begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end
        ST_TRIGGERED: begin
          // The write that exhausts post_rem closes the capture window.
          if (rec_stb) begin
            post_rem <= post_rem - 1'b1;
            if (post_rem == PTR_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (dump_start && !dump_q) begin
            rd_ptr   <= start_ptr;
            dump_rem <= {1'b0, pre_cnt} + DUMP_BASE;
            rd_req   <= 1'b1;
            state    <= ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (rec_valid && rec_ready) begin
            rec_valid <= 1'b0;
            rd_ptr    <= rd_ptr + 1'b1;
            dump_rem  <= dump_rem - 1'b1;
            if (dump_rem == (PTR_W+1)'(1)) begin
              rec_count <= '0;
              state     <= ST_IDLE;
            end else begin
              rd_req <= 1'b1;
            end
          end else if (rd_req) begin
            rec_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_trace_capture.sv
// Directed bench for bus_trace_capture at DEPTH=16, PRE_TRIG=4, AD_W=32.
module tb_bus_trace_capture;
  import bus_trace_pkg::*;

  localparam int AD_W        = 32;
  localparam int DEPTH       = 16;
  localparam int PRE_TRIG    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int REC_W       = rec_w(AD_W);
  localparam int CW          = $clog2(DEPTH) + 1;

  logic             comm_clock = 1'b0;
  logic             reset = 1'b1;
  logic             arm = 1'b0;
  logic             force_trigger = 1'b0;
  logic             dump_start = 1'b0;
  logic [AD_W-1:0]  trig_addr = '0;
  logic [AD_W-1:0]  trig_mask = '0;
  logic             bus_as_n = 1'b1;
  logic             bus_ds_n = 1'b1;
  logic             bus_rw = 1'b1;
  logic             bus_berr_n = 1'b1;
  logic [1:0]       bus_dsack_n = 2'b11;
  logic [AD_W-1:0]  bus_ad = '0;
  logic [REC_W-1:0] rec_data;
  logic             rec_valid;
  logic             rec_ready = 1'b0;
  logic [2:0]       capture_state;
  logic [CW-1:0]    rec_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 comm_clock = ~comm_clock;

  bus_trace_capture #(
    .AD_W        (AD_W),
    .DEPTH       (DEPTH),
    .PRE_TRIG    (PRE_TRIG),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .comm_clock    (comm_clock),
    .reset         (reset),
    .arm           (arm),
    .force_trigger (force_trigger),
    .dump_start    (dump_start),
    .trig_addr     (trig_addr),
    .trig_mask     (trig_mask),
    .bus_as_n      (bus_as_n),
    .bus_ds_n      (bus_ds_n),
    .bus_rw        (bus_rw),
    .bus_berr_n    (bus_berr_n),
    .bus_dsack_n   (bus_dsack_n),
    .bus_ad        (bus_ad),
    .rec_data      (rec_data),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .capture_state (capture_state),
    .rec_count     (rec_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge comm_clock);
    #1;
  endtask

  task automatic arm_pulse;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  // kind: 0 = DSACK0 termination, 1 = BERR termination, 2 = AS released unterminated
  task automatic bus_cycle(input logic [31:0] a, input int kind);
    bus_ad = a;
    bus_rw = 1'b1;
    tick;
    bus_as_n = 1'b0;
    bus_ds_n = 1'b0;
    tick;
    tick;
    bus_ad = a ^ 32'hA5A5_0000;
    if (kind == 0) bus_dsack_n = 2'b10;
    else if (kind == 1) bus_berr_n = 1'b0;
    tick;
    tick;
    bus_as_n    = 1'b1;
    bus_ds_n    = 1'b1;
    bus_dsack_n = 2'b11;
    bus_berr_n  = 1'b1;
    bus_ad      = '0;
    repeat (4) tick;
  endtask

  task automatic run_dump(input logic [31:0] first, input int n, input bit slow,
                          input logic [3:0] first_flags);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [REC_W-1:0] held = '0;
    logic [31:0] ea;
    dump_start = 1'b1;
    tick;
    dump_start = 1'b0;
    while (got < n && cyc < 1000) begin
      rec_ready = slow ? (cyc % 4 == 0) : 1'b1;
      if (rec_valid) begin
        if (stalled) check("stall_stable", 128'(rec_data), 128'(held));
        if (rec_ready) begin
          ea = first + 32'(got);
          check("dump_addr", 128'(rec_data[REC_W-1 -: 32]), 128'(ea));
          check("dump_data", 128'(rec_data[REC_W-33 -: 32]), 128'(ea ^ 32'hA5A5_0000));
          check("dump_flags", 128'(rec_data[REC_W-65 -: 4]),
                128'((got == 0) ? first_flags : 4'h9));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = rec_data;
        end
      end
      tick;
      cyc++;
    end
    rec_ready = 1'b0;
    check("dump_count", 128'(got), 128'(n));
    check("dump_valid_drop", 128'(rec_valid), 128'(0));
    check("dump_idle", 128'(capture_state), 128'(ST_IDLE));
    check("dump_count_clr", 128'(rec_count), 128'(0));
  endtask

  initial begin
    int w;
    repeat (3) tick;
    reset = 1'b0;
    check("reset_state", 128'(capture_state), 128'(ST_IDLE));
    check("reset_valid", 128'(rec_valid), 128'(0));
    check("reset_data", 128'(rec_data), 128'(0));
    check("reset_count", 128'(rec_count), 128'(0));

    // Address trigger at 0x105 with full pre-trigger history, fast consumer.
    trig_addr = 32'h105;
    trig_mask = '1;
    arm_pulse;
    check("t1_armed", 128'(capture_state), 128'(ST_ARMED));
    for (int i = 0; i < 17; i++) begin
      bus_cycle(32'h100 + i, 0);
      if (i == 4)  check("t1_pre_armed", 128'(capture_state), 128'(ST_ARMED));
      if (i == 5)  check("t1_trig", 128'(capture_state), 128'(ST_TRIGGERED));
      if (i == 15) check("t1_post", 128'(capture_state), 128'(ST_TRIGGERED));
    end
    check("t1_done", 128'(capture_state), 128'(ST_DONE));
    check("t1_count", 128'(rec_count), 128'(17));
    run_dump(32'h101, 16, 1'b0, 4'h9);

    // Same capture, consumer ready one cycle in four.
    arm_pulse;
    for (int i = 0; i < 17; i++) bus_cycle(32'h100 + i, 0);
    check("t4_done", 128'(capture_state), 128'(ST_DONE));
    run_dump(32'h101, 16, 1'b1, 4'h9);

    // Trigger on the very first record.
    trig_addr = 32'h200;
    arm_pulse;
    for (int i = 0; i < 12; i++) bus_cycle(32'h200 + i, 0);
    check("t2_done", 128'(capture_state), 128'(ST_DONE));
    run_dump(32'h200, 12, 1'b0, 4'h9);

    // Reset in the middle of a dump.
    arm_pulse;
    for (int i = 0; i < 12; i++) bus_cycle(32'h200 + i, 0);
    dump_start = 1'b1;
    tick;
    dump_start = 1'b0;
    w = 0;
    while (!rec_valid && w < 20) begin
      tick;
      w++;
    end
    check("t5_dump_valid", 128'(rec_valid), 128'(1));
    reset = 1'b1;
    tick;
    check("t5_dump_rst_state", 128'(capture_state), 128'(ST_IDLE));
    check("t5_dump_rst_valid", 128'(rec_valid), 128'(0));
    check("t5_dump_rst_count", 128'(rec_count), 128'(0));
    reset = 1'b0;
    tick;

    // Reset while TRIGGERED.
    trig_addr = 32'h400;
    arm_pulse;
    bus_cycle(32'h400, 0);
    bus_cycle(32'h401, 0);
    check("t5_trig_state", 128'(capture_state), 128'(ST_TRIGGERED));
    reset = 1'b1;
    tick;
    check("t5_trig_rst_state", 128'(capture_state), 128'(ST_IDLE));
    check("t5_trig_rst_valid", 128'(rec_valid), 128'(0));
    check("t5_trig_rst_count", 128'(rec_count), 128'(0));
    reset = 1'b0;
    tick;

    // force_trigger with arm in the same cycle is dropped; a later one in ARMED counts.
    trig_addr     = '1;
    trig_mask     = '1;
    arm           = 1'b1;
    force_trigger = 1'b1;
    tick;
    arm           = 1'b0;
    force_trigger = 1'b0;
    for (int i = 0; i < 3; i++) bus_cycle(32'h300 + i, 0);
    check("t3_still_armed", 128'(capture_state), 128'(ST_ARMED));
    force_trigger = 1'b1;
    tick;
    force_trigger = 1'b0;
    bus_cycle(32'h303, 0);
    check("t3_forced", 128'(capture_state), 128'(ST_TRIGGERED));
    for (int i = 4; i < 14; i++) bus_cycle(32'h300 + i, 0);
    check("t3_post", 128'(capture_state), 128'(ST_TRIGGERED));
    bus_cycle(32'h30E, 0);
    check("t3_done", 128'(capture_state), 128'(ST_DONE));
    run_dump(32'h300, 15, 1'b0, 4'h9);

    // Unterminated AS cycle is discarded; BERR-terminated cycle is recorded.
    trig_mask = '0;
    arm_pulse;
    bus_cycle(32'h500, 2);
    check("t6_abort_count", 128'(rec_count), 128'(0));
    check("t6_abort_state", 128'(capture_state), 128'(ST_ARMED));
    bus_cycle(32'h501, 1);
    check("t6_berr_count", 128'(rec_count), 128'(1));
    check("t6_berr_state", 128'(capture_state), 128'(ST_TRIGGERED));
    for (int i = 2; i < 13; i++) bus_cycle(32'h500 + i, 0);
    check("t6_done", 128'(capture_state), 128'(ST_DONE));
    run_dump(32'h501, 12, 1'b0, 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
